// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes, writeback FSM states and
// the forwarding-history entry layout.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_SW = 3'd4;
    localparam logic [OP_W-1:0] OP_LW = 3'd5;
    localparam logic [OP_W-1:0] OP_BR = 3'd6;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } wb_state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  tgt;
        logic [DATA_W-1:0] data;
    } hist_entry_t;

endpackage

// File: rtl/writeback_fwd_if.sv
// Writeback-stage bus: instruction slot, memory return, register-file write
// port and forwarding queries. WB_PERF_CNT_EN adds the perf counter outputs.
interface writeback_fwd_if;
    import cpu_pkg::*;

    logic              bubble_in;
    logic [REG_W-1:0]  tgt_in;
    logic [OP_W-1:0]   opcode_in;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_result;
    logic              mem_valid;
    logic              stall_out;
    logic              we;
    logic [REG_W-1:0]  wr_tgt;
    logic [DATA_W-1:0] wr_data;
    logic              mem_err;
    logic [REG_W-1:0]  qa_addr;
    logic [REG_W-1:0]  qb_addr;
    logic              qa_hit;
    logic              qb_hit;
    logic [DATA_W-1:0] qa_data;
    logic [DATA_W-1:0] qb_data;
    logic [REG_W-1:0]  wb_tgt_out;
    logic [DATA_W-1:0] wb_result_out;
`ifdef WB_PERF_CNT_EN
    logic [31:0]       perf_retired;
    logic [31:0]       perf_stall;
`endif

    modport master (
        output bubble_in, tgt_in, opcode_in, alu_result, mem_result, mem_valid,
        output qa_addr, qb_addr,
        input  stall_out, we, wr_tgt, wr_data, mem_err,
        input  qa_hit, qb_hit, qa_data, qb_data, wb_tgt_out, wb_result_out
`ifdef WB_PERF_CNT_EN
        , input perf_retired, perf_stall
`endif
    );

    modport slave (
        input  bubble_in, tgt_in, opcode_in, alu_result, mem_result, mem_valid,
        input  qa_addr, qb_addr,
        output stall_out, we, wr_tgt, wr_data, mem_err,
        output qa_hit, qb_hit, qa_data, qb_data, wb_tgt_out, wb_result_out
`ifdef WB_PERF_CNT_EN
        , output perf_retired, perf_stall
`endif
    );

endinterface

// File: rtl/fwd_history.sv
// Committed-write history (entry 0 youngest) with two priority lookups;
// a write in the current cycle bypasses the history.
module fwd_history
    import cpu_pkg::*;
#(
    parameter int unsigned HIST_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [REG_W-1:0]  push_tgt,
    input  logic [DATA_W-1:0] push_data,
    input  logic [REG_W-1:0]  qa_addr,
    input  logic [REG_W-1:0]  qb_addr,
    output logic              qa_hit,
    output logic [DATA_W-1:0] qa_data,
    output logic              qb_hit,
    output logic [DATA_W-1:0] qb_data,
    output logic [REG_W-1:0]  head_tgt,
    output logic [DATA_W-1:0] head_data
);

    hist_entry_t [HIST_DEPTH-1:0] hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (push) begin
            for (int unsigned i = 1; i < HIST_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
            hist[0] <= '{valid: 1'b1, tgt: push_tgt, data: push_data};
        end
    end

    // Result packs hit into .valid; register 0 never hits.
    function automatic hist_entry_t lookup(
        input logic [REG_W-1:0]          addr,
        input logic                      byp,
        input logic [REG_W-1:0]          byp_tgt,
        input logic [DATA_W-1:0]         byp_data,
        input hist_entry_t [HIST_DEPTH-1:0] h
    );
        hist_entry_t r;
        r = '0;
        if (addr != '0) begin
            if (byp && byp_tgt == addr) begin
                r = '{valid: 1'b1, tgt: addr, data: byp_data};
            end else begin
                for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
                    if (!r.valid && h[i].valid && h[i].tgt == addr) begin
                        r = h[i];
                    end
                end
            end
        end
        return r;
    endfunction

    hist_entry_t res_a;
    hist_entry_t res_b;

    always_comb begin
        res_a = lookup(qa_addr, push, push_tgt, push_data, hist);
        res_b = lookup(qb_addr, push, push_tgt, push_data, hist);
    end

    assign qa_hit    = res_a.valid;
    assign qa_data   = res_a.data;
    assign qb_hit    = res_b.valid;
    assign qb_data   = res_b.data;
    assign head_tgt  = hist[0].valid ? hist[0].tgt : '0;
    assign head_data = hist[0].data;

endmodule

// File: rtl/writeback_fwd.sv
// Writeback stage: result select, load-wait stall FSM with timeout flag, and
// forwarding history. Define WB_PERF_CNT_EN for retired/stall counters.
module writeback_fwd
    import cpu_pkg::*;
#(
    parameter int unsigned     HIST_DEPTH = 2,
    parameter int unsigned     MAX_WAIT   = 15
) (
    input  logic           clk,
    input  logic           rst,
    writeback_fwd_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    wb_state_t        state, state_nx;
    logic [CNT_W-1:0] wait_cnt, cnt_nx;
    logic             mem_err, err_nx;
    logic             stall;
    logic             is_load;
    logic             writes;
    logic             we;

    assign is_load = !bus.bubble_in && bus.opcode_in == OP_LW;
    assign writes  = !bus.bubble_in && bus.tgt_in != '0
                     && bus.opcode_in != OP_SW && bus.opcode_in != OP_BR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= cnt_nx;
            mem_err  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = wait_cnt;
        err_nx   = mem_err;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                if (is_load && !bus.mem_valid) begin
                    stall    = 1'b1;
                    state_nx = WAIT_MEM;
                    cnt_nx   = CNT_W'(1);
                end
            end
            WAIT_MEM: begin
                if (bus.mem_valid) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    stall = 1'b1;
                    if (wait_cnt == CNT_MAX) begin
                        err_nx = 1'b1;
                    end else begin
                        cnt_nx = wait_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign we            = writes && !stall;
    assign bus.we        = we;
    assign bus.stall_out = stall;
    assign bus.wr_tgt    = bus.tgt_in;
    assign bus.wr_data   = (bus.opcode_in == OP_LW) ? bus.mem_result : bus.alu_result;
    assign bus.mem_err   = mem_err;

    fwd_history #(
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .push      (we),
        .push_tgt  (bus.wr_tgt),
        .push_data (bus.wr_data),
        .qa_addr   (bus.qa_addr),
        .qb_addr   (bus.qb_addr),
        .qa_hit    (bus.qa_hit),
        .qa_data   (bus.qa_data),
        .qb_hit    (bus.qb_hit),
        .qb_data   (bus.qb_data),
        .head_tgt  (bus.wb_tgt_out),
        .head_data (bus.wb_result_out)
    );

`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (!bus.bubble_in && !stall) perf_retired <= perf_retired + 32'd1;
            if (stall)                    perf_stall   <= perf_stall + 32'd1;
        end
    end

    assign bus.perf_retired = perf_retired;
    assign bus.perf_stall   = perf_stall;
`endif

endmodule
